// File: rtl/tx_buf_pkg.sv
// rtl/tx_buf_pkg.sv - shared widths, RAM word layout and FSM encodings for tx_frame_buffer
package tx_buf_pkg;

  localparam int DATA_W = 64;
  localparam int USER_W = 80;
  localparam int KEEP_W = 8;
  localparam int WORD_W = 1 + KEEP_W + DATA_W;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } ram_word_t;

  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_DATA  = 2'd1;
  localparam logic [1:0] WR_DROP  = 2'd2;

  localparam logic [1:0] RD_IDLE  = 2'd0;
  localparam logic [1:0] RD_PRIME = 2'd1;
  localparam logic [1:0] RD_SEND  = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tx_frame_buffer_if.sv
// rtl/tx_frame_buffer_if.sv - 64-bit stream bundle with per-frame side info
interface tx_frame_buffer_if;
  import tx_buf_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/tx_buf_sdp_ram.sv
// rtl/tx_buf_sdp_ram.sv - simple dual-port RAM, one write port, registered read port
module tx_buf_sdp_ram
  import tx_buf_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // rd_data holds its value while rd_en is low; the reader relies on that
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tx_frame_buffer.sv
// rtl/tx_frame_buffer.sv - store-and-forward TX frame buffer with abort/overflow drop
// Optional frame/drop counters: TX_FRAME_BUFFER_STATS_EN
module tx_frame_buffer
  import tx_buf_pkg::*;
#(
  parameter int P_ADDR_W      = 9,
  parameter int P_INFO_ADDR_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  tx_frame_buffer_if.slave   s_axis,
  tx_frame_buffer_if.master  m_axis,
  input  logic               i_tx_abort
`ifdef TX_FRAME_BUFFER_STATS_EN
  ,
  output logic [15:0]        o_frame_cnt,
  output logic [15:0]        o_drop_cnt
`endif
);

  localparam int PW = P_ADDR_W + 1;
  localparam int IW = P_INFO_ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH      = {1'b1, {P_ADDR_W{1'b0}}};
  localparam logic [IW-1:0] INFO_DEPTH = {1'b1, {P_INFO_ADDR_W{1'b0}}};

  logic [1:0]          wr_state, rd_state;
  logic [PW-1:0]       wr_ptr, wr_cmt, rd_ptr;
  logic [IW-1:0]       info_wptr, info_rptr, frm_cnt;
  logic [USER_W-1:0]   cur_user, info_wdata, info_rdata;
  logic                rst_done;
  logic                beat, data_full, info_full, info_empty;
  logic                bad_beat, ram_we, commit;
  logic                send_st, send_hs, frame_done, pop, data_re;
  logic [P_ADDR_W-1:0] rd_addr;
  ram_word_t           ram_wdata, ram_rdata;

  // frm_cnt covers frames queued plus the one on the wire, so capacity is exact
  assign info_full  = (frm_cnt == INFO_DEPTH);
  assign info_empty = (info_wptr == info_rptr);
  assign data_full  = ((wr_ptr - rd_ptr) == DEPTH);

  assign s_axis.tready = rst_done & ((wr_state == WR_DROP) | ~info_full);
  assign beat       = s_axis.tvalid & s_axis.tready;
  assign bad_beat   = beat & (wr_state != WR_DROP) & (i_tx_abort | data_full);
  assign ram_we     = beat & (wr_state != WR_DROP) & ~bad_beat;
  assign commit     = ram_we & s_axis.tlast;
  assign info_wdata = (wr_state == WR_IDLE) ? s_axis.tuser : cur_user;
  assign ram_wdata  = {s_axis.tlast, (s_axis.tlast ? s_axis.tkeep : {KEEP_W{1'b1}}), s_axis.tdata};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_state <= WR_IDLE;
      wr_ptr   <= '0;
      wr_cmt   <= '0;
      cur_user <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (beat) begin
        case (wr_state)
          WR_IDLE, WR_DATA: begin
            if (bad_beat) begin
              wr_ptr   <= wr_cmt;
              wr_state <= s_axis.tlast ? WR_IDLE : WR_DROP;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_state == WR_IDLE) cur_user <= s_axis.tuser;
              if (s_axis.tlast) begin
                wr_cmt   <= wr_ptr + 1'b1;
                wr_state <= WR_IDLE;
              end else begin
                wr_state <= WR_DATA;
              end
            end
          end
          default: if (s_axis.tlast) wr_state <= WR_IDLE;
        endcase
      end
    end
  end

  // RAM output register doubles as the output stage: it only reloads on a handshake
  assign send_st    = (rd_state == RD_SEND);
  assign send_hs    = send_st & m_axis.tready;
  assign frame_done = send_hs & ram_rdata.last;
  assign pop        = ~info_empty & ((rd_state == RD_IDLE) | frame_done);
  assign data_re    = pop | (send_hs & ~ram_rdata.last);
  assign rd_addr    = rd_ptr[P_ADDR_W-1:0] + {{(P_ADDR_W-1){1'b0}}, send_st};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_state <= RD_IDLE;
      rd_ptr   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE:  if (pop) rd_state <= RD_PRIME;
        RD_PRIME: rd_state <= RD_SEND;
        RD_SEND: begin
          if (send_hs) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (ram_rdata.last) rd_state <= pop ? RD_PRIME : RD_IDLE;
          end
        end
        default:  rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      info_wptr <= '0;
      info_rptr <= '0;
      frm_cnt   <= '0;
    end else begin
      if (commit) info_wptr <= info_wptr + 1'b1;
      if (pop)    info_rptr <= info_rptr + 1'b1;
      case ({commit, frame_done})
        2'b10:   frm_cnt <= frm_cnt + 1'b1;
        2'b01:   frm_cnt <= frm_cnt - 1'b1;
        default: frm_cnt <= frm_cnt;
      endcase
    end
  end

  tx_buf_sdp_ram #(.WIDTH(WORD_W), .ADDR_W(P_ADDR_W)) u_data_ram (
    .clk     (i_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[P_ADDR_W-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (data_re),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  tx_buf_sdp_ram #(.WIDTH(USER_W), .ADDR_W(P_INFO_ADDR_W)) u_info_ram (
    .clk     (i_clk),
    .wr_en   (commit),
    .wr_addr (info_wptr[P_INFO_ADDR_W-1:0]),
    .wr_data (info_wdata),
    .rd_en   (pop),
    .rd_addr (info_rptr[P_INFO_ADDR_W-1:0]),
    .rd_data (info_rdata)
  );

  assign m_axis.tvalid = send_st;
  assign m_axis.tdata  = send_st ? ram_rdata.data : '0;
  assign m_axis.tkeep  = send_st ? ram_rdata.keep : '0;
  assign m_axis.tlast  = send_st & ram_rdata.last;
  assign m_axis.tuser  = send_st ? info_rdata : '0;

`ifdef TX_FRAME_BUFFER_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      if (commit)   o_frame_cnt <= sat_inc(o_frame_cnt);
      if (bad_beat) o_drop_cnt  <= sat_inc(o_drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_tx_frame_buffer.sv
// tb/tb_tx_frame_buffer.sv - scoreboard bench for tx_frame_buffer (16-beat data RAM)
module tb_tx_frame_buffer;
  import tx_buf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  tx_frame_buffer_if s_if ();
  tx_frame_buffer_if m_if ();
`ifdef TX_FRAME_BUFFER_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  tx_frame_buffer #(.P_ADDR_W(4), .P_INFO_ADDR_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .i_tx_abort (abort)
`ifdef TX_FRAME_BUFFER_STATS_EN
    ,
    .o_frame_cnt (frame_cnt),
    .o_drop_cnt  (drop_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [79:0] user;
  } beat_t;

  beat_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         rx_cnt = 0;
  bit         mon_en = 1'b1;
  int         rdy_mode = 1;
  logic [4:0] exp_wrp = '0;
  int         exp_frames = 0;
  int         exp_drops = 0;

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (mon_en && m_if.tvalid && m_if.tready) begin
        rx_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got data=%h last=%b, want no beat", m_if.tdata, m_if.tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== {e.data, e.keep, e.last, e.user}) begin
            bad++;
            $display("FAIL beat: got d=%h k=%h l=%b u=%h, want d=%h k=%h l=%b u=%h",
                     m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, e.data, e.keep, e.last, e.user);
          end
        end
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b0;
        1:       m_if.tready = 1'b1;
        default: m_if.tready = ~m_if.tready;
      endcase
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [79:0] u, input logic ab, output bit waited);
    int n;
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tuser = u;
    s_if.tvalid = 1'b1; abort = ab;
    waited = 1'b0; n = 0;
    @(negedge clk);
    while (!s_if.tready && n < 2000) begin
      waited = 1'b1; n++;
      @(negedge clk);
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL send_timeout: tready=%b want 1", s_if.tready);
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0; abort = 1'b0;
  endtask

  // abort_at is 1-based; 0 means no abort. Later beats carry ~u to prove tuser is sampled once.
  task automatic send_frame(input int len, input int id, input logic [7:0] lk, input logic [79:0] u,
                            input int abort_at, input bit good, output bit any_wait);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    bit          w;
    any_wait = 1'b0;
    for (int i = 0; i < len; i++) begin
      d = {16'hA5C3, 16'(id), 16'(i), 16'(id * 7 + i)};
      l = (i == len - 1);
      k = l ? lk : 8'hff;
      send_beat(d, k, l, (i == 0) ? u : ~u, (i == abort_at - 1), w);
      any_wait |= w;
      if (good) exp_q.push_back('{data: d, keep: k, last: l, user: u});
    end
    if (good) begin
      exp_wrp += 5'(len);
      exp_frames++;
    end else begin
      exp_drops++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (m_if.tvalid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_drain: tvalid=%b want 0", m_if.tvalid);
    end
  endtask

  task automatic test_reset();
    bit w;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready: got %b want 0", s_if.tready); end
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid: got %b want 0", m_if.tvalid); end
    total++; if (m_if.tdata !== 64'd0) begin bad++; $display("FAIL rst_m_tdata: got %h want 0", m_if.tdata); end
    total++; if (m_if.tuser !== 80'd0) begin bad++; $display("FAIL rst_m_tuser: got %h want 0", m_if.tuser); end
    total++; if (m_if.tkeep !== 8'd0) begin bad++; $display("FAIL rst_m_tkeep: got %h want 0", m_if.tkeep); end
    total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL rst_m_tlast: got %b want 0", m_if.tlast); end
    total++; if (dut.wr_state !== WR_IDLE) begin bad++; $display("FAIL rst_wr_state: got %0d want %0d", dut.wr_state, WR_IDLE); end
    total++; if (dut.rd_state !== RD_IDLE) begin bad++; $display("FAIL rst_rd_state: got %0d want %0d", dut.rd_state, RD_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL post_rst_tready: got %b want 1", s_if.tready); end
    w = 1'b0;
  endtask

  task automatic test_single_frame();
    bit w;
    rdy_mode = 1;
    send_frame(10, 1, 8'hfe, {16'd10, 48'd0, 16'h0800}, 0, 1'b1, w);
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL lat_n1: tvalid=%b want 0", m_if.tvalid); end
    @(posedge clk); #1;
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL lat_n2: tvalid=%b want 0", m_if.tvalid); end
    @(posedge clk); #1;
    total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL lat_n3: tvalid=%b want 1", m_if.tvalid); end
    wait_drain(200);
  endtask

  task automatic test_back_to_back();
    int         lens[4]  = '{3, 4, 2, 5};
    logic [7:0] keeps[4] = '{8'hff, 8'hfc, 8'hf0, 8'h80};
    int         rx0;
    bit         w;
    rx0 = rx_cnt;
    rdy_mode = 2;
    for (int f = 0; f < 4; f++)
      send_frame(lens[f], 10 + f, keeps[f], {16'(lens[f]), 48'h0000_1122_3300 + 48'(f), 16'h86dd}, 0, 1'b1, w);
    wait_drain(400);
    rdy_mode = 1;
    total++;
    if (rx_cnt - rx0 !== 14) begin bad++; $display("FAIL b2b_beats: got %0d want 14", rx_cnt - rx0); end
  endtask

  task automatic test_abort();
    bit w;
    rdy_mode = 1;
    send_frame(10, 20, 8'hff, {16'd10, 48'hdead, 16'h0800}, 5, 1'b0, w);
    total++;
    if (dut.wr_ptr !== exp_wrp) begin bad++; $display("FAIL abort_wr_ptr: got %0d want %0d", dut.wr_ptr, exp_wrp); end
    send_frame(6, 21, 8'hf8, {16'd6, 48'hbeef, 16'h0806}, 0, 1'b1, w);
    wait_drain(200);
  endtask

  task automatic test_overflow();
    bit w;
    rdy_mode = 1;
    send_frame(20, 30, 8'hff, {16'd20, 48'h0, 16'h0800}, 0, 1'b0, w);
    total++; if (w !== 1'b0) begin bad++; $display("FAIL ovf_tready: stalled=%b want 0", w); end
    total++; if (dut.wr_ptr !== exp_wrp) begin bad++; $display("FAIL ovf_wr_ptr: got %0d want %0d", dut.wr_ptr, exp_wrp); end
    send_frame(8, 31, 8'hc0, {16'd8, 48'h77, 16'h0800}, 0, 1'b1, w);
    wait_drain(200);
`ifdef TX_FRAME_BUFFER_STATS_EN
    total++; if (drop_cnt !== 16'(exp_drops)) begin bad++; $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, exp_drops); end
    total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
`endif
  endtask

  task automatic test_single_beats();
    bit w;
    rdy_mode = 0;
    for (int f = 0; f < 16; f++)
      send_frame(1, 40 + f, 8'he0, {16'd1, 48'(f), 16'h0800}, 0, 1'b1, w);
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL full16_tready: got %b want 0", s_if.tready); end
    rdy_mode = 1;
    send_frame(1, 56, 8'he0, {16'd1, 48'd16, 16'h0800}, 0, 1'b1, w);
    total++; if (w !== 1'b1) begin bad++; $display("FAIL frame17_waited: got %b want 1", w); end
    wait_drain(300);
  endtask

  task automatic test_reset_mid();
    bit w;
    int n;
    rdy_mode = 0;
    mon_en = 1'b0;
    send_frame(10, 60, 8'hff, {16'd10, 48'h1, 16'h0800}, 0, 1'b0, w);
    n = 0;
    while (!m_if.tvalid && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL mid_start: tvalid=%b want 1", m_if.tvalid); end
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL async_rst_tvalid: got %b want 0", m_if.tvalid); end
    total++; if (m_if.tdata !== 64'd0) begin bad++; $display("FAIL async_rst_tdata: got %h want 0", m_if.tdata); end
    @(negedge clk);
    rst = 1'b0;
    exp_wrp = '0; exp_frames = 0; exp_drops = 0;
    mon_en = 1'b1;
    n = 0;
    repeat (10) begin @(posedge clk); #1; if (m_if.tvalid) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL post_rst_idle: tvalid cycles=%0d want 0", n); end
    send_frame(3, 61, 8'hfe, {16'd3, 48'h2, 16'h0800}, 0, 1'b1, w);
    total++; if (dut.wr_ptr !== exp_wrp) begin bad++; $display("FAIL post_rst_wr_ptr: got %0d want %0d", dut.wr_ptr, exp_wrp); end
    wait_drain(200);
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    fork
      monitor();
      drive_ready();
    join_none
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_overflow();
    test_single_beats();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
